// File: rtl/rand_pick_pkg.sv
// rand_pick_pkg: shared state encoding, default sizing and pick width for rand_pick
package rand_pick_pkg;
  localparam int PICK_W        = 3;
  localparam int DEF_NUM_VALS  = 7;
  localparam int DEF_MAX_RETRY = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    OFFER  = 2'd2
  } state_t;
endpackage

// File: rtl/rand_pick_edge_rise.sv
// edge_rise: 1-bit rising-edge detector, delay flop resets to RST_VAL
module edge_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_d;
  // delay flop; resetting it high masks a level already high at reset release
  always_ff @(posedge clk) r_d <= rst ? RST_VAL : i_d;
  assign o_rise = i_d & ~r_d;
endmodule

// File: rtl/rand_pick.sv
// rand_pick: samples the random source on a request edge and offers one validated pick (macro NO_REPEAT_EN)
module rand_pick
  import rand_pick_pkg::*;
#(
  parameter int NUM_VALS  = DEF_NUM_VALS,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PICK_W-1:0]   r_in,
  input  logic                req,
  output logic [PICK_W-1:0]   pick,
  output logic                pick_valid,
  input  logic                pick_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    pick_count
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_t            r_state, w_next;
  logic [RW-1:0]     r_retry;
  logic [PICK_W-1:0] r_pick, r_last, w_force, w_val;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid, r_have_last;
  logic              w_edge, w_illegal, w_repeat, w_reject, w_exhausted, w_accept;

  edge_rise #(.RST_VAL(1'b1)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_d    (req),
    .o_rise (w_edge)
  );

  assign w_illegal = 32'(r_in) >= NUM_VALS;
`ifdef NO_REPEAT_EN
  assign w_repeat = r_have_last && (r_in == r_last);
`else
  assign w_repeat = 1'b0;
`endif
  assign w_reject    = w_illegal | w_repeat;
  assign w_exhausted = 32'(r_retry) == MAX_RETRY;
  assign w_accept    = ~w_reject | w_exhausted;
  assign w_force     = !r_have_last ? '0 : (32'(r_last) == NUM_VALS - 1) ? '0 : r_last + 3'd1;
  assign w_val       = w_reject ? w_force : r_in;

  assign pick       = r_pick;
  assign pick_valid = r_valid;
  assign pick_count = r_count;
  assign busy       = r_state != IDLE;

  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

  // next state: request edge starts sampling, accept moves to offer, handshake returns to idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_edge ? SAMPLE : IDLE;
      SAMPLE:  w_next = w_accept ? OFFER : SAMPLE;
      OFFER:   w_next = (r_valid & pick_ready) ? IDLE : OFFER;
      default: w_next = IDLE;
    endcase
  end

  // pick, history, retry and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pick      <= '0;
      r_valid     <= 1'b0;
      r_count     <= '0;
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_retry     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_edge) r_retry <= '0;
        SAMPLE: begin
          if (w_accept) begin
            r_pick      <= w_val;
            r_last      <= w_val;
            r_have_last <= 1'b1;
            r_valid     <= 1'b1;
          end else begin
            r_retry <= r_retry + RW'(1);
          end
        end
        OFFER: begin
          if (r_valid & pick_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rand_pick.sv
// tb_rand_pick: table-driven and randomized self-checking bench for rand_pick
module tb_rand_pick;
  logic       clk = 1'b0;
  logic       rst, req, pick_ready, pick_valid, busy;
  logic [2:0] r_in, pick;
  logic [7:0] pick_count;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         m_hl;
  logic [2:0] m_last;
  logic [7:0] m_cnt;

`ifdef NO_REPEAT_EN
  localparam bit NR = 1'b1;
`else
  localparam bit NR = 1'b0;
`endif

  typedef struct packed {
    logic [14:0] s;
    logic [2:0]  p;
    logic [3:0]  lat;
    logic [3:0]  dly;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  rand_pick dut (
    .clk        (clk),
    .rst        (rst),
    .r_in       (r_in),
    .req        (req),
    .pick       (pick),
    .pick_valid (pick_valid),
    .pick_ready (pick_ready),
    .busy       (busy),
    .pick_count (pick_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic logic [14:0] mk(input logic [2:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // first acceptable sample wins; five rejections fall back to the successor of the last pick
  function automatic void model(input logic [14:0] s, output logic [2:0] p, output int lat);
    for (int i = 0; i < 5; i++) begin
      logic [2:0] v;
      v = s[3*i +: 3];
      if (v < 3'd7 && !(NR && m_hl && v == m_last)) begin
        p = v;
        lat = i + 2;
        return;
      end
    end
    p = !m_hl ? 3'd0 : (m_last == 3'd6 ? 3'd0 : m_last + 3'd1);
    lat = 6;
  endfunction

  task automatic do_pick(input logic [14:0] s, input logic [2:0] ep, input int el, input int dly);
    int lat;
    lat = 0;
    req = 1'b0;
    tick;
    chk("idle_before_req", busy, 0);
    req = 1'b1;
    r_in = 3'($urandom);
    while (1) begin
      tick;
      lat++;
      if (pick_valid || lat > 12) break;
      if (lat == 1) chk("busy_in_sample", busy, 1);
      r_in = (lat <= 5) ? s[3*(lat-1) +: 3] : 3'($urandom);
      pick_ready = 1'($urandom);
      req = 1'($urandom);
    end
    chk("valid_latency", lat, el);
    if (!pick_valid) return;
    chk("pick_value", pick, ep);
    chk("count_hold_offer", pick_count, m_cnt);
    m_hl = 1'b1;
    m_last = ep;
    pick_ready = (dly == 0);
    for (int i = 0; i < dly; i++) begin
      r_in = 3'($urandom);
      req = 1'($urandom);
      tick;
      chk("stall_pick", pick, ep);
      chk("stall_valid", pick_valid, 1);
      chk("stall_count", pick_count, m_cnt);
      chk("stall_busy", busy, 1);
      if (i == dly - 1) pick_ready = 1'b1;
    end
    tick;
    m_cnt++;
    chk("hs_valid_low", pick_valid, 0);
    chk("hs_count", pick_count, m_cnt);
    chk("hs_idle", busy, 0);
    chk("hs_pick_held", pick, ep);
    pick_ready = 1'b0;
    req = 1'b0;
    tick;
    chk("no_queued_edge", busy, 0);
  endtask

  initial begin
    logic [14:0] s;
    logic [2:0]  p;
    int          lat;
    tbl[0] = '{mk(3'd7, 3'd7, 3'd7, 3'd7, 3'd7), 3'd0, 4'd6, 4'd0};
    tbl[1] = '{mk(3'd4, 3'd7, 3'd7, 3'd7, 3'd7), 3'd4, 4'd2, 4'd0};
    tbl[2] = '{mk(3'd7, 3'd7, 3'd2, 3'd7, 3'd7), 3'd2, 4'd4, 4'd1};
    tbl[3] = '{mk(3'd6, 3'd7, 3'd7, 3'd7, 3'd7), 3'd6, 4'd2, 4'd0};
    tbl[4] = '{mk(3'd7, 3'd7, 3'd7, 3'd7, 3'd7), 3'd0, 4'd6, 4'd2};
    tbl[5] = '{mk(3'd3, 3'd7, 3'd7, 3'd7, 3'd7), 3'd3, 4'd2, 4'd0};
    tbl[6] = '{mk(3'd7, 3'd7, 3'd7, 3'd7, 3'd7), 3'd4, 4'd6, 4'd0};
    tbl[7] = '{mk(3'd5, 3'd7, 3'd7, 3'd7, 3'd7), 3'd5, 4'd2, 4'd10};
`ifdef NO_REPEAT_EN
    tbl[8] = '{mk(3'd5, 3'd5, 3'd1, 3'd7, 3'd7), 3'd1, 4'd4, 4'd0};
`else
    tbl[8] = '{mk(3'd5, 3'd5, 3'd1, 3'd7, 3'd7), 3'd5, 4'd2, 4'd0};
`endif
    rst = 1'b1;
    req = 1'b0;
    pick_ready = 1'b0;
    r_in = 3'd0;
    m_hl = 1'b0;
    m_last = 3'd0;
    m_cnt = 8'd0;
    tick;
    tick;
    chk("rst_pick", pick, 0);
    chk("rst_valid", pick_valid, 0);
    chk("rst_count", pick_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      do_pick(tbl[i].s, tbl[i].p, int'(tbl[i].lat), int'(tbl[i].dly));
    req = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    m_hl = 1'b0;
    m_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("req_held_busy", busy, 0);
      chk("req_held_valid", pick_valid, 0);
    end
    chk("req_held_count", pick_count, 0);
    do_pick(mk(3'd2, 3'd7, 3'd7, 3'd7, 3'd7), 3'd2, 2, 0);
    req = 1'b0;
    tick;
    req = 1'b1;
    tick;
    r_in = 3'd3;
    tick;
    chk("abort_valid_before", pick_valid, 1);
    chk("abort_pick_before", pick, 3);
    rst = 1'b1;
    tick;
    chk("abort_valid", pick_valid, 0);
    chk("abort_count", pick_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pick", pick, 0);
    rst = 1'b0;
    req = 1'b0;
    m_hl = 1'b0;
    m_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(0, 3) == 0) s = mk(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      else
        for (int k = 0; k < 5; k++)
          s[3*k +: 3] = ($urandom_range(0, 3) == 0) ? 3'd7 :
                        ($urandom_range(0, 2) == 0 && m_hl) ? m_last : 3'($urandom_range(0, 7));
      model(s, p, lat);
      do_pick(s, p, lat, $urandom_range(0, 3));
    end
    chk("count_wrap", pick_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
